// File: rtl/uart_ctrl.sv
// Full-duplex UART: valid/ready transmitter and mid-bit-sampling receiver with frame/parity error flags.
// Latency: tx start bit one cycle after accept; rx_valid BIT_CYC/2+(DATA_BITS+P+1)*BIT_CYC after synced edge (+2 sync).
// Backpressure: tx_ready low for the whole frame; receiver never stalls. Parity is built only with UART_PARITY_EN.
module uart_ctrl #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (BIT_CYC < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t                 tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic                   tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic                   tx_par_q, tx_par_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d = S_START;
                    tx_sh_d    = tx_data;
                    tx_idx_d   = '0;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_idx_q == DATA_LAST) begin
                        tx_idx_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = S_PARITY;
`else
                        tx_state_d = S_STOP;
`endif
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == STOP_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // The line level is derived from the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = tx_par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        tx_ready = (tx_state_q == S_IDLE);
    end

    assign tx = tx_q;

    // ---------------- receiver ----------------
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    state_t                 rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_stop_smp;
`ifdef UART_PARITY_EN
    logic                   rx_par_q, rx_par_d;
    logic                   rx_perr_q, rx_perr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) begin
                        rx_idx_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = S_PARITY;
`else
                        rx_state_d = S_STOP;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_stop_smp = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_LAST);
        rx_valid_d  = rx_stop_smp;
        rx_data_d   = rx_stop_smp ? rx_sh_q : rx_data_q;
        rx_ferr_d   = rx_stop_smp ? !rx_s2_q : rx_ferr_q;
`ifdef UART_PARITY_EN
        rx_perr_d   = rx_stop_smp ? ((^rx_sh_q) ^ rx_par_q ^ 1'(PARITY_ODD)) : rx_perr_q;
`endif
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl at BIT_CYC=16, 8 data bits, 1 stop bit: tx waveform checks plus an rx scoreboard.
module tb_uart_ctrl;

    localparam int BC   = 16;
`ifdef UART_PARITY_EN
    localparam int P    = 1;
`else
    localparam int P    = 0;
`endif
    localparam int FRAME = 1 + 8 + P + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx;
    logic       loop = 1'b1;
    logic       rx_drv = 1'b1;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    assign rx_line = loop ? tx : rx_drv;

    uart_ctrl #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
        .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected_valid: got data 0x%0h with no frame expected", rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", rx_data, e.d);
                chk("rx_frame_err", rx_frame_err, e.fe);
                chk("rx_parity_err", rx_parity_err, e.pe);
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        exp_q.push_back(e);
    endtask

    // Send one byte and check every cycle of the tx waveform and tx_ready.
    task automatic tx_send_check(input logic [7:0] d);
        logic [15:0] bits;
        int bad;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_PARITY_EN
        bits[9] = ^d;
`endif
        @(negedge clk);
        chk("tx_ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        bad = 0;
        for (int b = 0; b < FRAME; b++) begin
            for (int c = 0; c < BC; c++) begin
                @(negedge clk);
                if (tx !== bits[b] || tx_ready !== 1'b0) bad++;
            end
        end
        chk("tx_wave_bad_cycles", bad, 0);
        @(negedge clk);
        chk("tx_ready_after_frame", tx_ready, 1);
        chk("tx_idle_high", tx, 1);
    endtask

    // Drive a frame directly onto rx, optionally corrupting stop or parity.
    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic flip_par);
        logic [15:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_PARITY_EN
        bits[9] = (^d) ^ flip_par;
`endif
        bits[FRAME-1] = stop_v;
        loop = 1'b0;
        for (int b = 0; b < FRAME; b++) begin
            @(negedge clk);
            rx_drv = bits[b];
            repeat (BC - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BC) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_frame_err", rx_frame_err, 0);
        chk("rst_rx_parity_err", rx_parity_err, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain send of 0xA5, looped back into the receiver.
        loop = 1'b1;
        push_exp(8'hA5, 1'b0, 1'b0);
        tx_send_check(8'hA5);
        repeat (20) @(negedge clk);

        // Back-to-back 0x3C then 0xC3 with tx_valid held; data change mid-frame must be ignored.
        @(negedge clk);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hC3, 1'b0, 1'b0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hC3;
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) hi++;
            else if (hi > 0) break;
        end
        chk("b2b_ready_high_cycles", hi, 1);
        chk("b2b_start_no_gap", tx, 0);
        tx_valid = 1'b0;
        repeat (FRAME * BC + 40) @(negedge clk);

        // Glitch of 4 cycles: no frame; then a clean 0x5A proves the receiver is idle.
        loop   = 1'b0;
        rx_drv = 1'b1;
        repeat (5) @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BC) @(negedge clk);
        push_exp(8'h5A, 1'b0, 1'b0);
        drive_frame(8'h5A, 1'b1, 1'b0);

        // Stop bit forced low.
        push_exp(8'h55, 1'b1, 1'b0);
        drive_frame(8'h55, 1'b0, 1'b0);

`ifdef UART_PARITY_EN
        loop = 1'b1;
        push_exp(8'h07, 1'b0, 1'b0);
        tx_send_check(8'h07);
        repeat (20) @(negedge clk);
        push_exp(8'h07, 1'b0, 1'b1);
        drive_frame(8'h07, 1'b1, 1'b1);
`endif

        // Reset in the middle of data bits on both paths, then a clean 0x81.
        loop = 1'b1;
        @(negedge clk);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (BC * 3 + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        push_exp(8'h81, 1'b0, 1'b0);
        tx_send_check(8'h81);
        repeat (60) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Parametrised full-duplex UART controller: a transmitter with a valid/ready input handshake and a receiver with start-bit validation and error reporting. Data width, stop-bit count and parity are configurable. It sits between a byte-stream producer/consumer and the board-level `tx`/`rx` pins, and replaces the fixed 8N1 UART for all new designs.

## Interface
- `CLK_FREQ`, default 1000000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s. `BIT_CYC = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `DATA_BITS`, default 8: payload width; legal values 5–9.
- `STOP_BITS`, default 1: legal values 1–2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Only used when `UART_PARITY_EN` is defined.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  byte to send; sampled on the accept cycle.
- `tx_valid`  in  1  producer has data.
- `tx_ready`  out  1  transmitter idle, can accept data.
- `tx`  out  1  serial output; idles high.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  last received payload.
- `rx_valid`  out  1  one-cycle pulse when a frame completes.
- `rx_frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`.
- `rx_parity_err`  out  1  parity mismatch; qualified by `rx_valid`.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, both error flags 0. Both FSMs go to IDLE and counters clear. Reset during a frame aborts it immediately; no partial byte is reported.
- Frame format, LSB first: start (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1). `FRAME = 1 + DATA_BITS + P + STOP_BITS`.
- **TX FSM** (IDLE → START → DATA → PARITY → STOP → IDLE):
  - Accept when `tx_valid && tx_ready`. `tx_data` is latched into the shift register and `tx_ready` falls on the next cycle.
  - Each state holds `tx` for exactly BIT_CYC cycles, counted by a per-bit counter that clears on every state or bit change.
  - DATA shifts out bit 0 first and uses a bit index from 0 to DATA_BITS-1.
  - STOP repeats STOP_BITS times.
  - PARITY is skipped when parity is compiled out.
- **RX path**: `rx` passes through a 2-flop synchronizer; FSM decisions use the synchronized value.
- **RX FSM** (IDLE → START → DATA → PARITY → STOP → IDLE):
  - IDLE: a 1→0 transition on the synchronized `rx` enters START.
  - START: waits BIT_CYC/2 cycles, then samples. If the sample is 1 it is a false start; return to IDLE with no output.
  - DATA, PARITY, STOP: each samples once after BIT_CYC cycles, i.e. at mid-bit. Data shifts in LSB first.
  - Only the first stop bit is checked.
  - At the STOP sample: update `rx_data` and the error flags, pulse `rx_valid` for one cycle, then enter IDLE. The FSM can detect a new start edge on the next cycle.
- Errors do not suppress `rx_data`; the consumer decides what to do with a flagged frame.
- TX and RX are fully independent; simultaneous activity is legal.

## Timing
- TX latency: accept on cycle N → `tx`=0 from cycle N+1.
- TX frame: `tx` holds each bit for BIT_CYC cycles. `tx_ready` rises in the cycle after the last stop bit's final cycle.
- Back-to-back TX: with `tx_valid` held high, `tx_ready` is high for exactly one cycle. The next start bit follows with no idle gap beyond that cycle.
- RX latency: synchronized falling edge to `rx_valid` = `BIT_CYC/2 + (DATA_BITS+P+1)*BIT_CYC` cycles, plus 2 synchronizer cycles measured from the pin.
- `rx_data` and the error flags hold until the next `rx_valid`.
- `tx_data` changes while `tx_ready`=0 have no effect.

## Configuration
- `UART_PARITY_EN` defined:
  - The parity bit is generated on TX and checked on RX.
  - Even parity (PARITY_ODD=0) makes the XOR of data and parity bits equal 0; odd parity makes it 1.
- `UART_PARITY_EN` undefined:
  - No parity bit on the line (P=0).
  - `rx_parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.
  - No parity logic is synthesized.

## Test plan
Use CLK_FREQ=1600, BAUD=100 (BIT_CYC=16), DATA_BITS=8, STOP_BITS=1 unless stated.
- Send 0xA5 with parity off → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. `tx_ready` is low for 160 cycles, then high.
- Loop `tx` to `rx` and send 0x3C, then 0xC3 with `tx_valid` held → two `rx_valid` pulses, `rx_data`=0x3C then 0xC3, errors 0. `tx_ready` is high for exactly 1 cycle between the frames.
- Drive `rx` low for 4 cycles, then high → no `rx_valid`, RX FSM back in IDLE.
- Receive a frame with the stop bit forced to 0, data 0x55 → `rx_valid` pulse, `rx_data`=0x55, `rx_frame_err`=1.
- With `UART_PARITY_EN` defined and PARITY_ODD=0, send 0x07 → parity bit on `tx` is 1. On RX, flip the parity bit → `rx_parity_err`=1 and `rx_data`=0x07.
- Assert `rst_n`=0 mid-DATA on both paths → `tx`=1 and `tx_ready`=1 immediately, no `rx_valid`. A subsequent 0x81 frame is received correctly.
